// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver FSM states, scan-code constants and small helpers.
// Also used by the downstream effect-parameter entry FSM.
package ps2_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DATA   = 3'd1,
        S_PARITY = 3'd2,
        S_STOP   = 3'd3,
        S_DONE   = 3'd4
    } ps2_state_e;

    localparam int unsigned SCAN_W = 8;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;

    localparam logic [7:0] SC_DIGIT_0 = 8'h45;
    localparam logic [7:0] SC_DIGIT_1 = 8'h16;
    localparam logic [7:0] SC_DIGIT_2 = 8'h1E;
    localparam logic [7:0] SC_DIGIT_3 = 8'h26;
    localparam logic [7:0] SC_DIGIT_4 = 8'h25;
    localparam logic [7:0] SC_DIGIT_5 = 8'h2E;
    localparam logic [7:0] SC_DIGIT_6 = 8'h36;
    localparam logic [7:0] SC_DIGIT_7 = 8'h3D;
    localparam logic [7:0] SC_DIGIT_8 = 8'h3E;
    localparam logic [7:0] SC_DIGIT_9 = 8'h46;

    // Odd parity: data bits plus parity bit must contain an odd number of ones.
    function automatic logic frame_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

    function automatic logic [7:0] digit_code(input logic [3:0] digit);
        logic [7:0] code;
        case (digit)
            4'd0:    code = SC_DIGIT_0;
            4'd1:    code = SC_DIGIT_1;
            4'd2:    code = SC_DIGIT_2;
            4'd3:    code = SC_DIGIT_3;
            4'd4:    code = SC_DIGIT_4;
            4'd5:    code = SC_DIGIT_5;
            4'd6:    code = SC_DIGIT_6;
            4'd7:    code = SC_DIGIT_7;
            4'd8:    code = SC_DIGIT_8;
            4'd9:    code = SC_DIGIT_9;
            default: code = 8'h00;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/ps2_key_receiver_if.sv
// PS/2 keyboard pins plus the decoded key outputs.
// master = receiver side, slave = keyboard/consumer side.
interface ps2_key_receiver_if;
    logic       PS2_CLK;
    logic       PS2_DAT;
    logic [7:0] ps2_key_data;
    logic       ps2_key_pressed;
    logic       ps2_frame_error;

    modport master (
        input  PS2_CLK, PS2_DAT,
        output ps2_key_data, ps2_key_pressed, ps2_frame_error
    );

    modport slave (
        output PS2_CLK, PS2_DAT,
        input  ps2_key_data, ps2_key_pressed, ps2_frame_error
    );
endinterface

// File: rtl/ps2_line_filter.sv
// 2-flop synchronisers for PS2_CLK/PS2_DAT, debounce on the clock line and a
// registered falling-edge strobe. The data line is only synchronised.
module ps2_line_filter #(
    parameter int unsigned FILTER_CYCLES = 8
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clk_raw_i,
    input  logic dat_raw_i,
    output logic fall_o,
    output logic dat_o
);
    localparam int unsigned CNT_W = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES + 1);

    logic [1:0]       clk_sync_q, dat_sync_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fall_q, fall_d;
    logic             settle_c;

    // The FILTER_CYCLES-th consecutive sample that differs from the filtered level.
    assign settle_c = (clk_sync_q[1] != level_q) && (cnt_q == CNT_W'(FILTER_CYCLES - 1));

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        fall_d  = settle_c && level_q;
        if (settle_c) begin
            level_d = clk_sync_q[1];
        end else if (clk_sync_q[1] != level_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            level_q    <= 1'b1;
            cnt_q      <= '0;
            fall_q     <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], clk_raw_i};
            dat_sync_q <= {dat_sync_q[0], dat_raw_i};
            level_q    <= level_d;
            cnt_q      <= cnt_d;
            fall_q     <= fall_d;
        end
    end

    assign fall_o = fall_q;
    assign dat_o  = dat_sync_q[1];
endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 frame receiver: start/8 data/odd parity/stop with watchdog abort.
// Define PS2_BREAK_FILTER_EN to suppress break (F0 xx) and E0 prefix bytes.
module ps2_key_receiver
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES  = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic               Clock,
    input  logic               Reset,
    ps2_key_receiver_if.master ps2_io
);
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    ps2_state_e       state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       count_q, count_d;
    logic             parity_q, parity_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;
    logic [7:0]       data_q, data_d;
    logic             pressed_q, pressed_d;
    logic             error_q, error_d;
    logic             fall, dat;
    logic             timeout_c, stop_ok_c;

    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_line_filter (
        .Clock     (Clock),
        .Reset     (Reset),
        .clk_raw_i (ps2_io.PS2_CLK),
        .dat_raw_i (ps2_io.PS2_DAT),
        .fall_o    (fall),
        .dat_o     (dat)
    );

    assign timeout_c = (state_q != S_IDLE) && (wdog_q == WD_W'(TIMEOUT_CYCLES));
    assign stop_ok_c = dat && frame_parity_ok(shift_q, parity_q);

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; a timeout overrides any coincident edge
    always_comb begin
        state_d = state_q;
        if (timeout_c) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (fall && !dat) state_d = S_DATA;
                S_DATA:   if (fall && count_q == 3'd7) state_d = S_PARITY;
                S_PARITY: if (fall) state_d = S_STOP;
                S_STOP:   if (fall) state_d = stop_ok_c ? S_DONE : S_IDLE;
                S_DONE:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

`ifdef PS2_BREAK_FILTER_EN
    logic brk_q, brk_d;

    // Break flag: set by F0, consumed by the following valid byte, cleared by errors
    always_comb begin
        brk_d = brk_q;
        if (error_d)                 brk_d = 1'b0;
        else if (state_q == S_DONE)  brk_d = brk_q ? 1'b0 : (shift_q == SC_BREAK);
    end

    always_ff @(posedge Clock) begin
        if (Reset) brk_q <= 1'b0;
        else       brk_q <= brk_d;
    end
`endif

    // Datapath and output next values
    always_comb begin
        shift_d   = shift_q;
        count_d   = count_q;
        parity_d  = parity_q;
        wdog_d    = (state_q == S_IDLE || fall) ? '0 : wdog_q + WD_W'(1);
        data_d    = data_q;
        pressed_d = 1'b0;
        error_d   = 1'b0;
        if (timeout_c) begin
            error_d = 1'b1;
            shift_d = '0;
            count_d = '0;
            wdog_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fall && dat) begin
                        error_d = 1'b1;
                    end else if (fall) begin
                        shift_d = '0;
                        count_d = '0;
                    end
                end
                S_DATA: begin
                    if (fall) begin
                        shift_d[count_q] = dat;
                        count_d          = count_q + 3'd1;
                    end
                end
                S_PARITY: if (fall) parity_d = dat;
                S_STOP:   if (fall && !stop_ok_c) error_d = 1'b1;
                S_DONE: begin
`ifdef PS2_BREAK_FILTER_EN
                    if (!brk_q && shift_q != SC_BREAK && shift_q != SC_EXT) begin
                        data_d    = shift_q;
                        pressed_d = 1'b1;
                    end
`else
                    data_d    = shift_q;
                    pressed_d = 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            shift_q   <= '0;
            count_q   <= '0;
            parity_q  <= 1'b0;
            wdog_q    <= '0;
            data_q    <= 8'h00;
            pressed_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            count_q   <= count_d;
            parity_q  <= parity_d;
            wdog_q    <= wdog_d;
            data_q    <= data_d;
            pressed_q <= pressed_d;
            error_q   <= error_d;
        end
    end

    assign ps2_io.ps2_key_data    = data_q;
    assign ps2_io.ps2_key_pressed = pressed_q;
    assign ps2_io.ps2_frame_error = error_q;
endmodule

// File: tb/tb_ps2_key_receiver.sv
// Directed bench for ps2_key_receiver: drives PS/2 frames on the raw pins and
// compares decoded data plus pulse counts against hand-computed values.
module tb_ps2_key_receiver;
    localparam int unsigned FILT = 8;
    localparam int unsigned TMO  = 400;
    localparam int unsigned HALF = 30;

`ifdef PS2_BREAK_FILTER_EN
    localparam int unsigned EXP_MAKE_BREAK_PULSES = 1;
    localparam int unsigned EXP_E0_PULSES         = 0;
    localparam logic [7:0]  EXP_E0_DATA           = 8'h5A;
`else
    localparam int unsigned EXP_MAKE_BREAK_PULSES = 3;
    localparam int unsigned EXP_E0_PULSES         = 1;
    localparam logic [7:0]  EXP_E0_DATA           = 8'hE0;
`endif

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    ps2_key_receiver_if bus_if ();

    ps2_key_receiver #(.FILTER_CYCLES(FILT), .TIMEOUT_CYCLES(TMO)) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .ps2_io (bus_if)
    );

    int   n_checks  = 0;
    int   n_fail    = 0;
    int   press_cnt = 0;
    int   err_cnt   = 0;
    logic prev_press = 1'b0;
    logic consec     = 1'b0;

    // Pulse counters sampled on the inactive edge
    always @(negedge Clock) begin
        if (bus_if.ps2_key_pressed) press_cnt++;
        if (bus_if.ps2_frame_error) err_cnt++;
        if (bus_if.ps2_key_pressed && prev_press) consec = 1'b1;
        prev_press = bus_if.ps2_key_pressed;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int unsigned n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    // One PS/2 bit cell; optional short opposite-level glitches in each half
    task automatic ps2_bit(input logic b, input bit glitch);
        bus_if.PS2_DAT = b;
        if (glitch) begin
            wait_clk(10); bus_if.PS2_CLK = 1'b0;
            wait_clk(3);  bus_if.PS2_CLK = 1'b1;
            wait_clk(HALF - 13);
        end else begin
            wait_clk(HALF);
        end
        bus_if.PS2_CLK = 1'b0;
        if (glitch) begin
            wait_clk(10); bus_if.PS2_CLK = 1'b1;
            wait_clk(3);  bus_if.PS2_CLK = 1'b0;
            wait_clk(HALF - 13);
        end else begin
            wait_clk(HALF);
        end
        bus_if.PS2_CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit flip, input bit glitch);
        ps2_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) ps2_bit(d[i], glitch);
        ps2_bit((~^d) ^ flip, glitch);
        ps2_bit(1'b1, glitch);
        wait_clk(2 * HALF);
    endtask

    int p0, e0;

    initial begin
        bus_if.PS2_CLK = 1'b1;
        bus_if.PS2_DAT = 1'b1;
        Reset = 1'b1;
        wait_clk(5);
        check_eq("rst_data",    32'(bus_if.ps2_key_data),    32'h00);
        check_eq("rst_pressed", 32'(bus_if.ps2_key_pressed), 32'h0);
        check_eq("rst_error",   32'(bus_if.ps2_frame_error), 32'h0);
        Reset = 1'b0;
        wait_clk(5);

        // Good frame 0x16
        p0 = press_cnt; e0 = err_cnt;
        send_frame(8'h16, 1'b0, 1'b0);
        check_eq("f16_data",  32'(bus_if.ps2_key_data), 32'h16);
        check_eq("f16_press", 32'(press_cnt - p0), 32'd1);
        check_eq("f16_err",   32'(err_cnt - e0),   32'd0);

        // Parity error on 0x45
        p0 = press_cnt; e0 = err_cnt;
        send_frame(8'h45, 1'b1, 1'b0);
        check_eq("par_err",   32'(err_cnt - e0),   32'd1);
        check_eq("par_data",  32'(bus_if.ps2_key_data), 32'h16);
        check_eq("par_press", 32'(press_cnt - p0), 32'd0);

        // Start bit with DAT high is rejected in idle
        e0 = err_cnt;
        ps2_bit(1'b1, 1'b0);
        wait_clk(2 * HALF);
        check_eq("start_err", 32'(err_cnt - e0), 32'd1);

        // Stalled frame: start plus 4 data bits, then watchdog
        p0 = press_cnt; e0 = err_cnt;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0);
        wait_clk(TMO + 1 + 2 * HALF);
        check_eq("tmo_err",   32'(err_cnt - e0),   32'd1);
        check_eq("tmo_press", 32'(press_cnt - p0), 32'd0);
        p0 = press_cnt; e0 = err_cnt;
        send_frame(8'h1E, 1'b0, 1'b0);
        check_eq("tmo_next_data",  32'(bus_if.ps2_key_data), 32'h1E);
        check_eq("tmo_next_press", 32'(press_cnt - p0), 32'd1);
        check_eq("tmo_next_err",   32'(err_cnt - e0),   32'd0);

        // Make / break / make sequence for Enter
        p0 = press_cnt;
        send_frame(8'h5A, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b0);
        check_eq("brk_press", 32'(press_cnt - p0), 32'(EXP_MAKE_BREAK_PULSES));
        check_eq("brk_data",  32'(bus_if.ps2_key_data), 32'h5A);

        // Extended prefix byte
        p0 = press_cnt;
        send_frame(8'hE0, 1'b0, 1'b0);
        check_eq("ext_press", 32'(press_cnt - p0), 32'(EXP_E0_PULSES));
        check_eq("ext_data",  32'(bus_if.ps2_key_data), 32'(EXP_E0_DATA));

        // Glitchy clock line mid-frame
        p0 = press_cnt; e0 = err_cnt;
        send_frame(8'h3D, 1'b0, 1'b1);
        check_eq("glitch_data",  32'(bus_if.ps2_key_data), 32'h3D);
        check_eq("glitch_press", 32'(press_cnt - p0), 32'd1);
        check_eq("glitch_err",   32'(err_cnt - e0),   32'd0);

        // Reset after the 5th data bit, then a clean frame
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b0, 1'b0);
        Reset = 1'b1;
        wait_clk(3);
        check_eq("mid_rst_data", 32'(bus_if.ps2_key_data), 32'h00);
        Reset = 1'b0;
        wait_clk(4 * HALF);
        p0 = press_cnt; e0 = err_cnt;
        send_frame(8'h26, 1'b0, 1'b0);
        check_eq("post_rst_data",  32'(bus_if.ps2_key_data), 32'h26);
        check_eq("post_rst_press", 32'(press_cnt - p0), 32'd1);
        check_eq("post_rst_err",   32'(err_cnt - e0),   32'd0);

        check_eq("press_not_consecutive", 32'(consec), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_key_receiver.md
# ps2_key_receiver

Deserialises PS/2 keyboard frames from the raw PS2_CLK/PS2_DAT pins into 8-bit scan codes. It is the stage directly upstream of the effect-parameter entry FSM, which consumes `ps2_key_data` and `ps2_key_pressed`. Each frame is validated for start, odd parity and stop bits. Stalled frames are aborted by a watchdog, and break-code sequences are optionally suppressed so that only key presses raise `ps2_key_pressed`.

## Interface
- `FILTER_CYCLES`, default 8: consecutive equal synchronised samples required before a PS2_CLK level change is accepted.
- `TIMEOUT_CYCLES`, default 50000 (1 ms at 50 MHz): maximum Clock cycles allowed between accepted PS2_CLK falling edges inside a frame.
- `Clock`, in, 1: system clock, 50 MHz.
- `Reset`, in, 1: reset Reset, synchronous, active-high; clock Clock.
- `PS2_CLK`, in, 1: raw keyboard clock, asynchronous.
- `PS2_DAT`, in, 1: raw keyboard data, asynchronous.
- `ps2_key_data`, out, 8: last accepted scan code; held until the next accepted byte.
- `ps2_key_pressed`, out, 1: one-cycle pulse when `ps2_key_data` updates with a reportable byte.
- `ps2_frame_error`, out, 1: one-cycle pulse on a parity, start, stop or timeout failure.

## Operation
- PS2_CLK and PS2_DAT each pass through a 2-flop synchroniser.
- The synchronised PS2_CLK then passes through a glitch filter:
  - The filtered level changes only after `FILTER_CYCLES` identical samples.
  - A filtered 1→0 transition produces `fall`, a one-cycle strobe.
- The synchronised PS2_DAT is sampled on each `fall` cycle.
- FSM states:
  - **S_IDLE**: on `fall` with DAT=0 → S_DATA, with bit count 0. On `fall` with DAT=1, raise a frame error and stay in S_IDLE.
  - **S_DATA**: on each `fall`, shift DAT into bit[count] (LSB first) and increment count. After the 8th bit → S_PARITY.
  - **S_PARITY**: on `fall`, store DAT → S_STOP.
  - **S_STOP**: on `fall`, the frame is valid if DAT=1 and the XOR of the 8 data bits and the parity bit equals 1. Valid → S_DONE. Invalid → error pulse, then S_IDLE.
  - **S_DONE**: single cycle. Apply the reporting rule (Configuration), then → S_IDLE.
- Watchdog:
  - The counter clears on every `fall` and in S_IDLE, and increments in every other state.
  - When it reaches `TIMEOUT_CYCLES`, the FSM goes to S_IDLE with an error pulse, and the partial byte is discarded.
- If a frame error and `fall` occur in the same cycle, the error wins; that `fall` is not treated as a start bit.
- Reset mid-frame: the FSM goes to S_IDLE, shift register 0, count 0, watchdog 0, break flag 0, outputs at reset values. The next start bit begins a clean frame.

## Timing
- Reset values: `ps2_key_data`=8'h00, `ps2_key_pressed`=0, `ps2_frame_error`=0, FSM=S_IDLE.
- Pin-to-`fall` latency: 2 (sync) + `FILTER_CYCLES` Clock cycles after the raw PS2_CLK edge.
- `ps2_key_data` and `ps2_key_pressed` update in the cycle after S_DONE is entered. This is 2 cycles after the stop-bit `fall`.
- `ps2_key_pressed` is high for exactly 1 cycle per reported byte. It never asserts on consecutive cycles.
- `ps2_frame_error` asserts 1 cycle after the detecting event.
- There is no back-pressure: the consumer must sample during the pulse.

## Configuration
- Macro: `PS2_BREAK_FILTER_EN`.
- **Defined**:
  - Byte 8'hF0 sets the break flag. It updates neither `ps2_key_data` nor `ps2_key_pressed`.
  - The next valid byte clears the break flag and is also not reported.
  - Byte 8'hE0 is dropped silently.
  - A frame error clears the break flag.
- **Undefined**: every valid byte, including F0 and E0, updates `ps2_key_data` and pulses `ps2_key_pressed`.

## Structure
- Shared package `ps2_pkg` contains:
  - FSM state enum.
  - Constants SC_BREAK=8'hF0, SC_EXT=8'hE0, SC_ENTER=8'h5A.
  - Digit scan codes 0–9 (45,16,1E,26,25,2E,36,3D,3E,46), also used by the entry FSM.
- Sub-module `ps2_line_filter`: synchroniser plus `FILTER_CYCLES` debounce plus falling-edge strobe, applied to PS2_CLK. PS2_DAT uses only its synchroniser path.

## Test plan
- Send frame 8'h16 with correct parity → `ps2_key_data`=8'h16, one `ps2_key_pressed` pulse, no error.
- Send 8'h45 with parity flipped → `ps2_frame_error` pulse, `ps2_key_data` unchanged, no pressed pulse.
- Send 4 bits, then hold PS2_CLK high for `TIMEOUT_CYCLES`+1 cycles → error pulse. A following 8'h1E frame is received cleanly.
- With `PS2_BREAK_FILTER_EN`, send 8'h5A, F0, 5A → exactly one pressed pulse, data=8'h5A. Without the macro → three pulses, final data=8'h5A.
- Inject 3-cycle PS2_CLK glitches mid-frame with `FILTER_CYCLES`=8 → the byte is received correctly and no error is raised.
- Assert Reset after the 5th data bit, release it, then send 8'h26 → data=8'h26, one pressed pulse.
